exe_stage: RTL and testbench

- Execute stage of the 24-bit five-stage pipeline.
- Sits between the ID stage outputs and the ALU_to_MEM pipeline register.
- Contains the ID/EXE pipeline register, forwarding muxes and the ALU, including an iterative shift-add multiplier.
- Drives writeback_enable, mem_read_enable, mem_write_enable, instruction_dest, alu_result and write_data into ALU_to_MEM, and raises busy to stall IF/ID while a multiply is in flight.

---
 rtl/exe_stage.sv | 197 +++++++++++++++++++
 tb/tb_exe_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage
//  Description : Execute stage: ID/EXE register, operand forwarding, ALU and
//                an iterative shift-add multiplier that stalls IF/ID.
//  Revision    : 1.0
// ============================================================================
module exe_stage #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              is_imm_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic [ADDR_W-1:0] dest_in,
    input  logic [ADDR_W-1:0] src1_in,
    input  logic [ADDR_W-1:0] src2_in,
    input  logic [DATA_W-1:0] val1_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] reg2_in,
    input  logic              fwd_mem_en,
    input  logic              fwd_wb_en,
    input  logic [ADDR_W-1:0] fwd_mem_dest,
    input  logic [ADDR_W-1:0] fwd_wb_dest,
    input  logic [DATA_W-1:0] fwd_mem_val,
    input  logic [DATA_W-1:0] fwd_wb_val,
    output logic              busy,
    output logic              writeback_enable,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] instruction_dest,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_z
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [CMD_W-1:0] c_CMD_MOV = CMD_W'(0);
    localparam logic [CMD_W-1:0] c_CMD_ADD = CMD_W'(1);
    localparam logic [CMD_W-1:0] c_CMD_SUB = CMD_W'(2);
    localparam logic [CMD_W-1:0] c_CMD_AND = CMD_W'(3);
    localparam logic [CMD_W-1:0] c_CMD_OR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] c_CMD_XOR = CMD_W'(5);
    localparam logic [CMD_W-1:0] c_CMD_SLL = CMD_W'(6);
    localparam logic [CMD_W-1:0] c_CMD_SRL = CMD_W'(7);
    localparam logic [CMD_W-1:0] c_CMD_MUL = CMD_W'(8);

    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [4:0]       c_SH_LIMIT  = 5'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                wb_q, mr_q, mw_q, imm_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [ADDR_W-1:0]   dest_q, src1_q, src2_q;
    logic [DATA_W-1:0]   val1_q, val2_q, reg2_q;
    logic [DATA_W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   w_op_a, w_op_b, w_alu;
    logic [4:0]          w_shamt;

    // MEM-stage result is younger than WB-stage result, so it wins.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] src,
                                              input logic [DATA_W-1:0] v);
        if (forward_en && fwd_mem_en && (fwd_mem_dest == src))
            return fwd_mem_val;
        else if (forward_en && fwd_wb_en && (fwd_wb_dest == src))
            return fwd_wb_val;
        else
            return v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q   <= 1'b0;
            mr_q   <= 1'b0;
            mw_q   <= 1'b0;
            imm_q  <= 1'b0;
            cmd_q  <= '0;
            dest_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            val1_q <= '0;
            val2_q <= '0;
            reg2_q <= '0;
        end else if (!busy) begin
            wb_q   <= wb_en_in;
            mr_q   <= mem_r_en_in;
            mw_q   <= mem_w_en_in;
            imm_q  <= is_imm_in;
            cmd_q  <= exe_cmd_in;
            dest_q <= dest_in;
            src1_q <= src1_in;
            src2_q <= src2_in;
            val1_q <= val1_in;
            val2_q <= val2_in;
            reg2_q <= reg2_in;
        end
    end

    always_comb begin
        w_op_a     = fwd(src1_q, val1_q);
        w_op_b     = imm_q ? val2_q : fwd(src2_q, val2_q);
        write_data = fwd(src2_q, reg2_q);
        w_shamt    = w_op_b[4:0];
    end

    always_comb begin
        w_alu = w_op_a;
        case (cmd_q)
            c_CMD_MOV: w_alu = w_op_b;
            c_CMD_ADD: w_alu = w_op_a + w_op_b;
            c_CMD_SUB: w_alu = w_op_a - w_op_b;
            c_CMD_AND: w_alu = w_op_a & w_op_b;
            c_CMD_OR:  w_alu = w_op_a | w_op_b;
            c_CMD_XOR: w_alu = w_op_a ^ w_op_b;
            c_CMD_SLL: w_alu = (w_shamt >= c_SH_LIMIT) ? '0 : (w_op_a << w_shamt);
            c_CMD_SRL: w_alu = (w_shamt >= c_SH_LIMIT) ? '0 : (w_op_a >> w_shamt);
            c_CMD_MUL: w_alu = acc_q;
            default:   w_alu = w_op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Operands are captured only on leaving IDLE; forwarding is ignored afterwards.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_q == c_CMD_MUL) begin
                    busy     = 1'b1;
                    mcand_d  = w_op_a;
                    mplier_d = w_op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == c_CNT_LAST)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        writeback_enable = wb_q & ~busy;
        mem_read_enable  = mr_q & ~busy;
        mem_write_enable = mw_q & ~busy;
        instruction_dest = dest_q;
        alu_result       = w_alu;
        flag_z           = (w_alu == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_stage
//  Description : Self-checking bench for exe_stage against a behavioural model.
//  Revision    : 1.0
// ============================================================================
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        forward_en = 1'b0;
    logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, is_imm_in = 1'b0;
    logic [3:0]  exe_cmd_in = '0, dest_in = '0, src1_in = '0, src2_in = '0;
    logic [23:0] val1_in = '0, val2_in = '0, reg2_in = '0;
    logic        fwd_mem_en = 1'b0, fwd_wb_en = 1'b0;
    logic [3:0]  fwd_mem_dest = '0, fwd_wb_dest = '0;
    logic [23:0] fwd_mem_val = '0, fwd_wb_val = '0;
    logic        busy, writeback_enable, mem_read_enable, mem_write_enable, flag_z;
    logic [3:0]  instruction_dest;
    logic [23:0] alu_result, write_data;

    int checks = 0;
    int errors = 0;

    logic        cur_wb, cur_mr, cur_mw, cur_imm;
    logic [3:0]  cur_cmd, cur_dst, cur_s1, cur_s2;
    logic [23:0] cur_v1, cur_v2, cur_r2;

    exe_stage #(.DATA_W(24), .ADDR_W(4), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .is_imm_in(is_imm_in), .exe_cmd_in(exe_cmd_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .val1_in(val1_in), .val2_in(val2_in),
        .reg2_in(reg2_in), .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en),
        .fwd_mem_dest(fwd_mem_dest), .fwd_wb_dest(fwd_wb_dest),
        .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val), .busy(busy),
        .writeback_enable(writeback_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .instruction_dest(instruction_dest),
        .alu_result(alu_result), .write_data(write_data), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] m_fwd(input logic [3:0] src, input logic [23:0] v);
        if (forward_en && fwd_mem_en && fwd_mem_dest == src) return fwd_mem_val;
        if (forward_en && fwd_wb_en && fwd_wb_dest == src) return fwd_wb_val;
        return v;
    endfunction

    function automatic logic [23:0] m_alu(input logic [3:0] cmd, input logic [23:0] a,
                                          input logic [23:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r;
        int     amt = int'(b[4:0]);
        case (int'(cmd))
            0: r = ub;
            1: r = ua + ub;
            2: r = ua + (64'd16777216 - ub);
            3: r = longint'(a & b);
            4: r = longint'(a | b);
            5: r = longint'(a ^ b);
            6: r = (amt >= 24) ? 0 : ua * (longint'(1) << amt);
            7: r = (amt >= 24) ? 0 : ua / (longint'(1) << amt);
            8: r = ua * ub;
            default: r = ua;
        endcase
        return r[23:0];
    endfunction

    task automatic drive_now(input int cmd, input logic wb, input logic mr, input logic mw,
                             input logic imm, input logic [3:0] dst, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [23:0] v1,
                             input logic [23:0] v2, input logic [23:0] r2);
        exe_cmd_in = 4'(cmd); wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
        is_imm_in = imm; dest_in = dst; src1_in = s1; src2_in = s2;
        val1_in = v1; val2_in = v2; reg2_in = r2;
        cur_cmd = 4'(cmd); cur_wb = wb; cur_mr = mr; cur_mw = mw; cur_imm = imm;
        cur_dst = dst; cur_s1 = s1; cur_s2 = s2; cur_v1 = v1; cur_v2 = v2; cur_r2 = r2;
    endtask

    task automatic issue(input int cmd, input logic wb, input logic mr, input logic mw,
                         input logic imm, input logic [3:0] dst, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [23:0] v1,
                         input logic [23:0] v2, input logic [23:0] r2);
        @(negedge clk);
        drive_now(cmd, wb, mr, mw, imm, dst, s1, s2, v1, v2, r2);
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input logic fe, input logic me, input logic [3:0] md,
                           input logic [23:0] mv, input logic we, input logic [3:0] wd,
                           input logic [23:0] wv);
        forward_en = fe; fwd_mem_en = me; fwd_mem_dest = md; fwd_mem_val = mv;
        fwd_wb_en = we; fwd_wb_dest = wd; fwd_wb_val = wv;
    endtask

    task automatic rand_fwd();
        set_fwd($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 3)),
                24'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 24'($urandom));
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, writeback_enable, mem_read_enable, mem_write_enable} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0000",
                     {busy, writeback_enable, mem_read_enable, mem_write_enable});
        end
        // Inputs presented during reset must not be captured.
        drive_now(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd1, 4'd2, 24'h12, 24'h34, 24'h56);
        @(posedge clk); #1;
        checks++;
        if ({alu_result, write_data, instruction_dest} !== 52'd0 || flag_z !== 1'b1
            || writeback_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: alu=%h wd=%h dest=%h z=%b wb=%b, want zeros z=1",
                     alu_result, write_data, instruction_dest, flag_z, writeback_enable);
        end
        @(negedge clk);
        drive_now(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 24'd0, 24'd0);
        rst = 1'b1;
    endtask

    task automatic test_forwarding();
        set_fwd(1'b1, 1'b1, 4'd3, 24'h000010, 1'b1, 4'd3, 24'h000020);
        issue(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 4'd9, 24'h000001, 24'h000005, 24'd0);
        checks++;
        if (alu_result !== 24'h000015) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %h, want 000015", alu_result);
        end
        forward_en = 1'b0;
        #1;
        checks++;
        if (alu_result !== 24'h000006) begin
            errors++;
            $display("FAIL fwd_disabled: got %h, want 000006", alu_result);
        end
        set_fwd(1'b1, 1'b0, 4'd3, 24'h000010, 1'b1, 4'd3, 24'h000020);
        #1;
        checks++;
        if (alu_result !== 24'h000025) begin
            errors++;
            $display("FAIL fwd_wb: got %h, want 000025", alu_result);
        end
        set_fwd(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_arith();
        issue(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'hFFFFFF, 24'h000001, 24'd0);
        checks++;
        if (alu_result !== 24'h000000 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: got %h z=%b, want 000000 z=1", alu_result, flag_z);
        end
        issue(2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'h000000, 24'h000001, 24'd0);
        checks++;
        if (alu_result !== 24'hFFFFFF || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap: got %h z=%b, want ffffff z=0", alu_result, flag_z);
        end
    endtask

    task automatic test_shift();
        issue(6, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'h000001, 24'd5, 24'd0);
        checks++;
        if (alu_result !== 24'h000020) begin
            errors++;
            $display("FAIL sll5: got %h, want 000020", alu_result);
        end
        issue(6, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'h000001, 24'd30, 24'd0);
        checks++;
        if (alu_result !== 24'h000000) begin
            errors++;
            $display("FAIL sll30: got %h, want 000000", alu_result);
        end
        issue(7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'h800000, 24'd23, 24'd0);
        checks++;
        if (alu_result !== 24'h000001) begin
            errors++;
            $display("FAIL srl23: got %h, want 000001", alu_result);
        end
        issue(7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 24'h800000, 24'd24, 24'd0);
        checks++;
        if (alu_result !== 24'h000000) begin
            errors++;
            $display("FAIL srl24: got %h, want 000000", alu_result);
        end
    endtask

    task automatic test_mul();
        int n = 0;
        int bad_wb = 0;
        issue(8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd1, 4'd0, 24'd3, 24'd5, 24'd0);
        // The following ADD waits on the inputs while the multiply stalls the stage.
        drive_now(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd1, 4'd0, 24'd7, 24'd8, 24'd0);
        while (busy === 1'b1 && n < 40) begin
            if (writeback_enable !== 1'b0) bad_wb++;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 25 || bad_wb != 0) begin
            errors++;
            $display("FAIL mul_busy: busy cycles=%0d wb_leaks=%0d, want 25 and 0", n, bad_wb);
        end
        checks++;
        if (alu_result !== 24'd15 || writeback_enable !== 1'b1 || instruction_dest !== 4'd4) begin
            errors++;
            $display("FAIL mul_done: alu=%h wb=%b dest=%h, want 00000f 1 4",
                     alu_result, writeback_enable, instruction_dest);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_result !== 24'd15 || instruction_dest !== 4'd9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_next_add: alu=%h dest=%h busy=%b, want 00000f 9 0",
                     alu_result, instruction_dest, busy);
        end
    endtask

    task automatic test_mul_reset();
        int n = 0;
        issue(8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 24'h001000, 24'h001000, 24'd0);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 25 || alu_result !== 24'd0 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL mul_trunc: cycles=%0d alu=%h z=%b, want 25 000000 1",
                     n, alu_result, flag_z);
        end
        issue(8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 24'd3, 24'd5, 24'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, writeback_enable, alu_result, instruction_dest} !== 30'd0) begin
            errors++;
            $display("FAIL mul_abort: busy=%b wb=%b alu=%h dest=%h, want zeros",
                     busy, writeback_enable, alu_result, instruction_dest);
        end
        @(negedge clk);
        drive_now(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd1, 4'd0, 24'd2, 24'd3, 24'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (alu_result !== 24'd5 || busy !== 1'b0 || writeback_enable !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_add: alu=%h busy=%b wb=%b, want 000005 0 1",
                     alu_result, busy, writeback_enable);
        end
    endtask

    task automatic test_store();
        set_fwd(1'b1, 1'b0, 4'd0, 24'd0, 1'b1, 4'd7, 24'hABCDEF);
        issue(1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 4'd7, 24'h000100, 24'd4, 24'h111111);
        checks++;
        if (alu_result !== 24'h000104 || write_data !== 24'hABCDEF
            || mem_write_enable !== 1'b1 || writeback_enable !== 1'b0) begin
            errors++;
            $display("FAIL store: alu=%h wd=%h mw=%b wb=%b, want 000104 abcdef 1 0",
                     alu_result, write_data, mem_write_enable, writeback_enable);
        end
        set_fwd(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_random();
        logic [23:0] ea, eb, er;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            rand_fwd();
            drive_now(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), 24'($urandom), 24'($urandom), 24'($urandom));
            ea = m_fwd(cur_s1, cur_v1);
            eb = cur_imm ? cur_v2 : m_fwd(cur_s2, cur_v2);
            er = m_alu(cur_cmd, ea, eb);
            @(posedge clk); #1;
            if (cur_cmd == 4'd8) begin
                int n = 0;
                int leaks = 0;
                while (busy === 1'b1 && n < 40) begin
                    if ({writeback_enable, mem_read_enable, mem_write_enable} !== 3'b0)
                        leaks++;
                    if (n > 0) rand_fwd();
                    n++;
                    @(posedge clk); #1;
                end
                checks++;
                if (n != 25 || leaks != 0) begin
                    errors++;
                    $display("FAIL rnd_mul_stall[%0d]: cycles=%0d leaks=%0d, want 25 0",
                             i, n, leaks);
                end
            end
            checks++;
            if (alu_result !== er || flag_z !== (er == 24'd0) || busy !== 1'b0
                || write_data !== m_fwd(cur_s2, cur_r2)
                || {writeback_enable, mem_read_enable, mem_write_enable}
                   !== {cur_wb, cur_mr, cur_mw}
                || instruction_dest !== cur_dst) begin
                errors++;
                $display("FAIL rnd_op[%0d] cmd=%0d: alu=%h z=%b wd=%h en=%b dest=%h busy=%b, want alu=%h wd=%h en=%b dest=%h",
                         i, cur_cmd, alu_result, flag_z, write_data,
                         {writeback_enable, mem_read_enable, mem_write_enable},
                         instruction_dest, busy, er, m_fwd(cur_s2, cur_r2),
                         {cur_wb, cur_mr, cur_mw}, cur_dst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_arith();
        test_shift();
        test_mul();
        test_mul_reset();
        test_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
